// File: rtl/local_oscillator_sequencer.sv
// Local-oscillator table read sequencer (ADC clock domain).
// Walks the LO table RAM from entry 0 up to a runtime last address, restarts
// phase on an external sync, flags syncs that arrive out of phase, and splits
// each 2-sample read word into registered cos/sin samples with valid/marker.
module local_oscillator_sequencer #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int SAMPLE_WIDTH  = 18
) (
  input  logic                      adcClk,
  input  logic                      adcReset_n,
  input  logic                      enable,
  input  logic [ADDRESS_WIDTH-1:0]  lastAddr,
  input  logic                      syncPulse,
  input  logic                      clearError,
  output logic [ADDRESS_WIDTH-1:0]  rAddr,
  input  logic [2*SAMPLE_WIDTH-1:0] rData,
  output logic [SAMPLE_WIDTH-1:0]   loCos,
  output logic [SAMPLE_WIDTH-1:0]   loSin,
  output logic                      loValid,
  output logic                      loMarker,
  output logic                      running,
  output logic                      resyncError,
  output logic [7:0]                resyncCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_RUN
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [ADDRESS_WIDTH-1:0]   r_last_addr;
  logic                       r_valid_p1;
  logic                       r_marker_p1;
  logic                       w_issue;
  logic                       w_wrap;
  logic                       w_restart;
  logic                       w_misaligned;
  logic                       w_relatch;

  // State register.
  always_ff @(posedge adcClk) begin
    if (!adcReset_n) r_state <= S_IDLE;
    else             r_state <= w_next_state;
  end

  // Next-state and per-cycle control decode; enable=0 overrides any sync.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (enable) w_next_state = S_WAIT_SYNC;
      S_WAIT_SYNC: begin
        if (!enable)        w_next_state = S_IDLE;
        else if (syncPulse) w_next_state = S_RUN;
      end
      S_RUN:       if (!enable) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
    w_issue      = (r_state == S_RUN) && enable;
    w_wrap       = (rAddr == r_last_addr);
    w_restart    = w_issue && (syncPulse || w_wrap);
    w_misaligned = w_issue && syncPulse && !w_wrap;
    w_relatch    = ((r_state == S_WAIT_SYNC) && enable && syncPulse) || w_restart;
  end

  assign running = (r_state == S_RUN);

  // Read address: counts while issuing, otherwise parked at 0.
  always_ff @(posedge adcClk) begin
    if (!adcReset_n)              rAddr <= '0;
    else if (w_issue && !w_restart) rAddr <= rAddr + 1'b1;
    else                          rAddr <= '0;
  end

  // Table length is only sampled at phase restarts so a pass is never cut short.
  always_ff @(posedge adcClk) begin
    if (!adcReset_n)    r_last_addr <= '0;
    else if (w_relatch) r_last_addr <= lastAddr;
  end

  // Two-stage valid/marker pipe matching the RAM read latency plus output register;
  // enable low squashes both stages so no stale sample escapes after leaving RUN.
  always_ff @(posedge adcClk) begin
    if (!adcReset_n) begin
      r_valid_p1  <= 1'b0;
      r_marker_p1 <= 1'b0;
      loValid     <= 1'b0;
      loMarker    <= 1'b0;
      loCos       <= '0;
      loSin       <= '0;
    end else begin
      r_valid_p1  <= w_issue;
      r_marker_p1 <= w_issue && (rAddr == '0);
      loValid     <= r_valid_p1 && enable;
      loMarker    <= r_marker_p1 && enable;
      if (r_valid_p1 && enable) begin
        loCos <= rData[SAMPLE_WIDTH-1:0];
        loSin <= rData[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
      end
    end
  end

  // Misaligned-sync bookkeeping; a new error outranks a simultaneous clear.
  always_ff @(posedge adcClk) begin
    if (!adcReset_n) begin
      resyncError <= 1'b0;
      resyncCount <= '0;
    end else if (w_misaligned) begin
      resyncError <= 1'b1;
      if (clearError)                resyncCount <= 8'd1;
      else if (resyncCount != '1)    resyncCount <= resyncCount + 8'd1;
    end else if (clearError) begin
      resyncError <= 1'b0;
      resyncCount <= '0;
    end
  end

endmodule

// File: tb/tb_local_oscillator_sequencer.sv
// Self-checking bench for local_oscillator_sequencer: a cycle-level reference
// model pushes each issued address into a scoreboard queue tagged with the
// cycle its sample must appear; outputs are checked one step after each edge.
module tb_local_oscillator_sequencer;

  localparam int AW = 10;
  localparam int SW = 18;

  logic            adcClk = 1'b0;
  logic            adcReset_n = 1'b0;
  logic            enable = 1'b0;
  logic [AW-1:0]   lastAddr = '0;
  logic            syncPulse = 1'b0;
  logic            clearError = 1'b0;
  logic [AW-1:0]   rAddr;
  logic [2*SW-1:0] rData = '0;
  logic [SW-1:0]   loCos;
  logic [SW-1:0]   loSin;
  logic            loValid;
  logic            loMarker;
  logic            running;
  logic            resyncError;
  logic [7:0]      resyncCount;

  local_oscillator_sequencer #(.ADDRESS_WIDTH(AW), .SAMPLE_WIDTH(SW)) dut (
    .adcClk(adcClk), .adcReset_n(adcReset_n), .enable(enable),
    .lastAddr(lastAddr), .syncPulse(syncPulse), .clearError(clearError),
    .rAddr(rAddr), .rData(rData), .loCos(loCos), .loSin(loSin),
    .loValid(loValid), .loMarker(loMarker), .running(running),
    .resyncError(resyncError), .resyncCount(resyncCount)
  );

  always #5 adcClk = ~adcClk;

  // Table RAM model with registered read: word = {sin=addr+100, cos=addr}.
  always @(posedge adcClk) rData <= {18'(rAddr) + 18'd100, 18'(rAddr)};

  typedef struct {
    int cyc;
    int addr;
    bit mark;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  // reference model: state 0=IDLE 1=WAIT_SYNC 2=RUN
  int   m_state = 0, m_addr = 0, m_last = 0, m_err = 0, m_cnt = 0;
  int   m_cos = 0, m_sin = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int  n_state, n_addr, n_last, n_err_f, n_cnt;
    bit  mis;
    exp_t e;
    n_state = m_state; n_addr = m_addr; n_last = m_last;
    n_err_f = m_err;   n_cnt  = m_cnt;  mis = 0;
    if (!adcReset_n) begin
      n_state = 0; n_addr = 0; n_last = 0; n_err_f = 0; n_cnt = 0;
      q.delete();
    end else if (!enable) begin
      n_state = 0; n_addr = 0;
      q.delete();
    end else begin
      case (m_state)
        0: n_state = 1;
        1: if (syncPulse) begin
             n_state = 2; n_addr = 0; n_last = int'(lastAddr);
           end
        default: begin
          q.push_back('{cyc: cyc + 2, addr: m_addr, mark: (m_addr == 0)});
          if (syncPulse) begin
            mis = (m_addr != m_last);
            n_addr = 0; n_last = int'(lastAddr);
          end else if (m_addr == m_last) begin
            n_addr = 0; n_last = int'(lastAddr);
          end else begin
            n_addr = m_addr + 1;
          end
        end
      endcase
      if (mis) begin
        n_err_f = 1;
        n_cnt   = clearError ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
      end else if (clearError) begin
        n_err_f = 0; n_cnt = 0;
      end
    end
    @(posedge adcClk);
    #1;
    cyc++;
    if (!adcReset_n) begin
      m_cos = 0; m_sin = 0;
    end
    m_state = n_state; m_addr = n_addr; m_last = n_last;
    m_err = n_err_f;   m_cnt = n_cnt;
    check_eq("rAddr", 32'(rAddr), m_addr);
    check_eq("running", 32'(running), 32'(m_state == 2));
    check_eq("resyncError", 32'(resyncError), m_err);
    check_eq("resyncCount", 32'(resyncCount), m_cnt);
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      m_cos = e.addr;
      m_sin = e.addr + 100;
      check_eq("loValid", 32'(loValid), 1);
      check_eq("loMarker", 32'(loMarker), 32'(e.mark));
    end else begin
      check_eq("loValid", 32'(loValid), 0);
      check_eq("loMarker", 32'(loMarker), 0);
    end
    check_eq("loCos", 32'(loCos), m_cos);
    check_eq("loSin", 32'(loSin), m_sin);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_addr(input int a);
    for (int i = 0; i < 40; i++) begin
      if (m_addr == a) break;
      step();
    end
    check_eq("wait_addr", 32'(rAddr), a);
  endtask

  task automatic pulse_sync(input bit with_clear);
    syncPulse  = 1'b1;
    clearError = with_clear;
    step();
    syncPulse  = 1'b0;
    clearError = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset, then enable with an 8-entry table and sync at cycle 10
    run(3);
    adcReset_n = 1'b1;
    enable     = 1'b1;
    lastAddr   = 10'd7;
    run(6);
    pulse_sync(1'b0);
    run(30);

    // aligned sync at last entry: no flag
    wait_addr(7);
    pulse_sync(1'b0);
    run(3);
    // misaligned sync at entry 3
    wait_addr(3);
    pulse_sync(1'b0);
    run(3);

    // clearError alone, then clear coinciding with a misaligned sync
    clearError = 1'b1;
    step();
    clearError = 1'b0;
    run(2);
    wait_addr(3);
    pulse_sync(1'b1);
    run(2);

    // 300 back-to-back misaligned syncs saturate the counter
    wait_addr(1);
    syncPulse = 1'b1;
    run(300);
    syncPulse = 1'b0;
    run(10);
    clearError = 1'b1;
    step();
    clearError = 1'b0;

    // table length 7 -> 3 mid-pass, then 0
    wait_addr(2);
    lastAddr = 10'd3;
    run(20);
    lastAddr = 10'd0;
    run(12);

    // enable low with a simultaneous sync aborts to IDLE
    lastAddr  = 10'd7;
    run(6);
    enable    = 1'b0;
    syncPulse = 1'b1;
    step();
    syncPulse = 1'b0;
    run(4);
    enable = 1'b1;
    run(5);
    pulse_sync(1'b0);
    run(12);

    // reset mid-RUN; a fresh sync is needed afterwards
    adcReset_n = 1'b0;
    run(2);
    adcReset_n = 1'b1;
    run(8);
    pulse_sync(1'b0);
    run(14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
